// File: rtl/clock24_count.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : clock24_count
// Description : 24-hour time-of-day datapath. Cascaded BCD seconds, minutes
//               and hours counters with adjust strobes and an hourly chime.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module clock24_count (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SIG1HZ,
    input  logic       SECCLR,
    input  logic       MININC,
    input  logic       HOURINC,
    output logic [7:0] SEC,
    output logic [7:0] MIN,
    output logic [7:0] HOUR,
    output logic       CHIME
);

    localparam logic [7:0] C_SEC_TOP  = 8'h59;
    localparam logic [7:0] C_MIN_TOP  = 8'h59;
    localparam logic [7:0] C_HOUR_TOP = 8'h23;

    logic [7:0] r_sec;
    logic [7:0] r_min;
    logic [7:0] r_hour;
    logic       r_chime;

    logic       w_sec_carry;
    logic       w_min_adv;
    logic       w_min_carry;
    logic       w_hour_adv;

    // Advance one BCD value by one; wraps to 00 when already at its top value.
    function automatic logic [7:0] f_bcd_inc(input logic [7:7-7] dummy_unused_w,
                                             input logic [7:0] v,
                                             input logic [7:0] top);
        logic [7:0] res;
        if (v == top) begin
            res = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            res = {v[7:4] + 4'd1, 4'd0};
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res ^ {7'd0, dummy_unused_w & 1'b0};
    endfunction

    // The minute carry only comes from a seconds wrap, never from an adjust strobe.
    assign w_sec_carry = SIG1HZ & ~SECCLR & (r_sec == C_SEC_TOP);
    assign w_min_adv   = w_sec_carry | MININC;
    assign w_min_carry = w_sec_carry & (r_min == C_MIN_TOP);
    assign w_hour_adv  = w_min_carry | HOURINC;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sec <= 8'h00;
        end else if (SECCLR) begin
            r_sec <= 8'h00;
        end else if (SIG1HZ) begin
            r_sec <= f_bcd_inc(1'b0, r_sec, C_SEC_TOP);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_min <= 8'h00;
        end else if (w_min_adv) begin
            r_min <= f_bcd_inc(1'b0, r_min, C_MIN_TOP);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hour <= 8'h00;
        end else if (w_hour_adv) begin
            r_hour <= f_bcd_inc(1'b0, r_hour, C_HOUR_TOP);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_chime <= 1'b0;
        end else begin
            r_chime <= w_min_carry;
        end
    end

    assign SEC   = r_sec;
    assign MIN   = r_min;
    assign HOUR  = r_hour;
    assign CHIME = r_chime;

endmodule
`default_nettype wire

// File: doc/clock24_count.md
# clock24_count

Time-of-day datapath for the 24-hour clock: three cascaded BCD counters (seconds, minutes, hours) advanced by the 1 Hz enable and adjusted by the single-cycle clear/increment strobes from the adjust-mode state machine. It is the consumer end of that state machine's SECCLR/MININC/HOURINC interface. Its BCD outputs feed the 7-segment display driver, which applies the blink enables separately.

## Interface
- No parameters. Ranges are fixed at 60/60/24.
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  reset, asynchronous, active-high. Clears all counters to 00:00:00.
- SIG1HZ  in  1  one-cycle enable, once per second. Advances seconds.
- SECCLR  in  1  one-cycle strobe. Sets seconds to 00.
- MININC  in  1  one-cycle strobe. Increments minutes, no carry to hours.
- HOURINC  in  1  one-cycle strobe. Increments hours.
- SEC  out  8  seconds BCD. [7:4] tens 0–5, [3:0] units 0–9.
- MIN  out  8  minutes BCD. Same encoding as SEC.
- HOUR  out  8  hours BCD. [7:4] tens 0–2, [3:0] units 0–9.
- CHIME  out  1  one-cycle pulse on the hour rollover produced by normal counting.

## Operation
- Every input is sampled each CLK edge. Each high cycle is one event; no edge detection is done here.
- **Seconds**
  - SECCLR=1: next SEC = 00, no carry. SECCLR has priority over SIG1HZ in the same cycle.
  - Otherwise SIG1HZ=1: SEC +1 in BCD. Units 9 wraps to 0 and increments tens.
  - At 59: SEC -> 00 and asserts the internal carry SC for that cycle.
- **Minutes**
  - Advances by exactly 1 when (SC | MININC). If both are high in the same cycle, the minute still advances by 1 only.
  - At 59: MIN -> 00.
  - The internal carry MC is asserted only when the advance came from SC, i.e. SC=1 and MIN=59. A MININC-only wrap never carries.
- **Hours**
  - Advances by exactly 1 when (MC | HOURINC). If both are high, the hour still advances by 1 only.
  - 23 -> 00. Units wrap 9 -> 0 with tens +1 (09->10, 19->20). At 23 the wrap goes to 00, not 24.
- **CHIME**
  - Registered output, equal to MC of the previous edge.
  - HOURINC never produces CHIME, including HOURINC at 23.
- **Validity**
  - Invalid BCD digit values are unreachable from reset. No recovery logic is required.
  - Every counter must stay within its stated digit ranges under any input sequence.

## Timing
- Reset values: SEC=8'h00, MIN=8'h00, HOUR=8'h00, CHIME=0.
  - Outputs go to these values immediately on RST assertion, without waiting for CLK.
  - While RST=1, inputs are ignored.
  - The first count occurs on the first posedge after deassertion at which an input is high.
- Latency is one cycle for all counters. An input high at edge N is reflected on SEC/MIN/HOUR after edge N.
  - A seconds carry updates SEC, MIN and HOUR on the same edge; there is no ripple delay.
- CHIME is high for exactly the one cycle following the edge on which HOUR advanced due to MC.
- Reset mid-operation (for example RST during a CHIME cycle): CHIME drops immediately and counters clear. No pending carry survives reset.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Reset then seconds rollover:** RST pulse, then 60 SIG1HZ pulses -> after the 59th SEC=8'h59 and MIN=8'h00; after the 60th SEC=8'h00, MIN=8'h01, CHIME=0.
- **Full-day wrap with chime:**
  - Preset: 23 HOURINC, 59 MININC, 59 SIG1HZ -> reach 23:59:59, CHIME stays 0 throughout.
  - One more SIG1HZ -> 00:00:00, and CHIME=1 for exactly one cycle.
  - Also check the digit wrap at HOUR 09 -> 10 -> ... -> 19 -> 20 while presetting.
- **SECCLR priority:** at 00:00:59, SECCLR and SIG1HZ high in the same cycle -> SEC=8'h00, MIN stays 8'h00, CHIME=0.
- **Adjust wraps without carry:**
  - MIN=59, one MININC -> MIN=8'h00, HOUR unchanged.
  - HOUR=23, one HOURINC -> HOUR=8'h00, CHIME=0.
- **Simultaneous carry and strobe:**
  - At 00:05:59, SIG1HZ and MININC in the same cycle -> 00:06:00, not 00:07:00.
  - At 12:59:59, SIG1HZ and HOURINC in the same cycle -> 13:00:00, and CHIME=1.
- **Async reset mid-count:** at 14:37:21, assert RST between clock edges -> all outputs read 00 before the next posedge; counting resumes from 00:00:00 after deassertion.
